// File: rtl/logic_op_pipe_if.sv
// Operand/result bus for logic_op_pipe.
// Signals:
//   in_valid/in_ready   input handshake for a, b, op
//   a, b                WIDTH-bit operands
//   op                  00 OR, 01 AND, 10 XOR, 11 ANDN (a & ~b)
//   out_valid/out_ready output handshake for c, c_any
//   c                   WIDTH-bit result
//   c_any               reduction OR of c
// Modports: slave = the pipe, master = the producer/consumer side.
interface logic_op_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             c_any;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, c_any
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, c_any
  );
endinterface

// File: rtl/logic_op_pipe.sv
// Pipelined two-operand bitwise logic unit with valid/ready flow control and
// a saturating count of delivered non-zero results.
// Ports:
//   clk      rising-edge clock
//   reset    async active-high reset, clears all state
//   bus      logic_op_pipe_if.slave: in/out handshakes, a, b, op, c, c_any
//   cnt_clr  synchronous clear of nz_cnt (wins over an increment)
//   nz_cnt   saturating count of output handshakes with c != 0
module logic_op_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  logic_op_pipe_if.slave       bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     nz_cnt
);

  localparam int unsigned        LAST    = STAGES - 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic                 rdy_q;
  logic [STAGES-1:0]    v_q;
  logic [STAGES-1:0]    any_q;
  logic [WIDTH-1:0]     d_q [STAGES];
  logic [STAGES-1:0]    free_c;
  logic [WIDTH-1:0]     res_c;
  logic                 in_fire_c;
  logic                 out_fire_c;

  // Stage k may load when it, or any stage downstream of it, is empty, or the
  // output is being consumed; evaluated back-to-front with a running term.
  always_comb begin : free_calc
    logic acc;
    acc    = bus.out_ready;
    free_c = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc       = !v_q[k] || acc;
      free_c[k] = acc;
    end
  end

  // rdy_q holds in_ready low until the first edge after reset release.
  assign bus.in_ready = rdy_q && free_c[0];
  assign in_fire_c    = bus.in_valid && bus.in_ready;
  assign out_fire_c   = v_q[LAST] && bus.out_ready;

  // The only place the op is evaluated; later stages just carry the result.
  always_comb begin
    res_c = '0;
    case (bus.op)
      2'b00:   res_c = bus.a | bus.b;
      2'b01:   res_c = bus.a & bus.b;
      2'b10:   res_c = bus.a ^ bus.b;
      default: res_c = bus.a & ~bus.b;
    endcase
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b0;
      v_q   <= '0;
      any_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        d_q[k] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (free_c[0]) begin
        v_q[0] <= in_fire_c;
      end
      if (in_fire_c) begin
        d_q[0]   <= res_c;
        any_q[0] <= |res_c;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (free_c[k]) begin
          v_q[k]   <= v_q[k-1];
          d_q[k]   <= d_q[k-1];
          any_q[k] <= any_q[k-1];
        end
      end
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.c         = d_q[LAST];
  assign bus.c_any     = any_q[LAST];

  // Non-zero result counter; clear has priority, increment saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_cnt <= '0;
    end else if (cnt_clr) begin
      nz_cnt <= '0;
    end else if (out_fire_c && any_q[LAST] && (nz_cnt != CNT_MAX)) begin
      nz_cnt <= nz_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: driver pushes reference results on each
// accepted beat, a negedge monitor pops and compares on each delivered beat.
module tb_logic_op_pipe;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic_op_pipe_if #(.WIDTH(WIDTH)) m_if ();
  logic_op_pipe_if #(.WIDTH(WIDTH)) s_if ();
  logic             cnt_clr;
  logic             cnt_clr2;
  logic [CNT_W-1:0] nz_cnt;
  logic [1:0]       nz_cnt2;

  logic_op_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(m_if.slave), .cnt_clr(cnt_clr), .nz_cnt(nz_cnt)
  );

  logic_op_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(s_if.slave), .cnt_clr(cnt_clr2), .nz_cnt(nz_cnt2)
  );

  typedef struct {
    logic [7:0] c;
    logic       any;
    int         acc_cyc;
  } exp_t;

  exp_t             sb[$];
  logic [7:0]       dir_q[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  bit               check_lat = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  bit               hold_v = 0;
  logic [7:0]       hold_c = '0;
  exp_t             mon_e;
  logic             mon_nz;
  logic [7:0]       mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      model_cnt = '0;
      hold_v    = 0;
    end else begin
      chk("nz_cnt_model", nz_cnt, model_cnt);
      if (hold_v && m_if.out_valid) chk("stall_hold_c", m_if.c, hold_c);
      hold_v = m_if.out_valid && !m_if.out_ready;
      hold_c = m_if.c;
      mon_nz = 1'b0;
      if (m_if.out_valid && m_if.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=no_output", m_if.c);
        end else begin
          mon_e  = sb.pop_front();
          mon_nz = mon_e.any;
          chk("c", m_if.c, mon_e.c);
          chk("c_any", m_if.c_any, mon_e.any);
          if (check_lat) chk("latency", cyc - mon_e.acc_cyc, STAGES);
          if (dir_q.size() > 0) chk("op_table_c", m_if.c, dir_q.pop_front());
        end
      end
      if (m_if.in_valid && m_if.in_ready) begin
        mon_r = ref_op(m_if.a, m_if.b, m_if.op);
        sb.push_back('{c: mon_r, any: (mon_r != 8'h00), acc_cyc: cyc});
      end
      if (cnt_clr) model_cnt = '0;
      else if (mon_nz && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bit acc;
    int n;
    n = 0;
    m_if.in_valid = 1'b1;
    m_if.a = a;
    m_if.b = b;
    m_if.op = op;
    do begin
      @(negedge clk);
      acc = m_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    m_if.in_valid = 1'b0;
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic drain();
    int n;
    bit done;
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b1;
    done = 0;
    for (n = 0; n < 60 && !done; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !m_if.out_valid) done = 1;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  initial begin
    logic [7:0] tbl [4];
    int t0;
    int accepted;
    bit acc;
    int seen;
    bit got;
    tbl[0] = 8'hDE; tbl[1] = 8'h48; tbl[2] = 8'h96; tbl[3] = 8'h82;

    m_if.in_valid = 0; m_if.a = 0; m_if.b = 0; m_if.op = 0; m_if.out_ready = 1;
    s_if.in_valid = 0; s_if.a = 0; s_if.b = 0; s_if.op = 0; s_if.out_ready = 1;
    cnt_clr = 0;
    cnt_clr2 = 0;

    // Reset state and in_ready release timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", m_if.out_valid, 0);
    chk("rst_c", m_if.c, 0);
    chk("rst_c_any", m_if.c_any, 0);
    chk("rst_nz_cnt", nz_cnt, 0);
    chk("rst_in_ready", m_if.in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_before_edge", m_if.in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_edge", m_if.in_ready, 1);

    // Op table at full throughput with latency check.
    @(posedge clk); #1;
    check_lat = 1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      dir_q.push_back(tbl[i]);
      send(8'hCA, 8'h5C, 2'(i));
    end
    chk("throughput_cycles", cyc - t0, 4);
    drain();
    check_lat = 0;
    chk("op_table_consumed", dir_q.size(), 0);

    // Backpressure: stall output for 5 cycles while streaming.
    m_if.out_ready = 1'b0;
    m_if.in_valid  = 1'b1;
    m_if.a = 8'($urandom); m_if.b = 8'($urandom); m_if.op = 2'($urandom);
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = m_if.in_ready;
      if (acc) accepted++;
      @(posedge clk); #1;
      if (acc) begin
        m_if.a = 8'($urandom); m_if.b = 8'($urandom); m_if.op = 2'($urandom);
      end
    end
    chk("accepts_until_full", accepted, STAGES);
    chk("in_ready_when_full", m_if.in_ready, 0);

    // Full pipeline: release and accept in the same cycle.
    m_if.out_ready = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", m_if.in_ready, 1);
    chk("simul_out_valid", m_if.out_valid, 1);
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 2'($urandom));
    drain();

    // Counter: 3 zero results, 4 non-zero.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    send(8'h00, 8'h00, 2'd0);
    send(8'hF0, 8'h0F, 2'd1);
    send(8'h3C, 8'h3C, 2'd2);
    for (int i = 0; i < 4; i++) send(8'($urandom) | 8'h01, 8'($urandom), 2'd0);
    drain();
    chk("nz_cnt_four", nz_cnt, 4);

    // Clear coincident with a non-zero output handshake.
    m_if.out_ready = 1'b0;
    send(8'h11, 8'h22, 2'd0);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (m_if.out_valid) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) fail_now("wait_out_valid");
    m_if.out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_beats_inc", nz_cnt, 0);
    drain();

    // Randomized traffic with random stalls and occasional clears.
    for (int i = 0; i < 300; i++) begin
      m_if.in_valid  = ($urandom_range(3) != 0);
      m_if.a         = 8'($urandom);
      m_if.b         = 8'($urandom);
      m_if.op        = 2'($urandom);
      m_if.out_ready = ($urandom_range(2) != 0);
      cnt_clr        = ($urandom_range(39) == 0);
      @(posedge clk); #1;
    end
    cnt_clr = 1'b0;
    drain();

    // Reset with two beats in flight.
    m_if.out_ready = 1'b0;
    send(8'hA5, 8'h0F, 2'd0);
    send(8'h5A, 8'hF0, 2'd2);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", m_if.out_valid, 0);
    chk("midrst_nz_cnt", nz_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_if.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_if.out_valid) seen++;
    end
    chk("no_stale_beats", seen, 0);

    // Saturation on the 2-bit counter instance.
    accepted = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      s_if.in_valid = 1'b1;
      s_if.a  = 8'($urandom) | 8'h80;
      s_if.b  = 8'($urandom);
      s_if.op = 2'd0;
      @(negedge clk);
      if (s_if.in_ready) accepted++;
      @(posedge clk); #1;
    end
    s_if.in_valid = 1'b0;
    chk("sat_accepts", accepted, 5);
    repeat (STAGES + 3) @(posedge clk);
    #1;
    chk("sat_nz_cnt", nz_cnt2, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_nz_cnt_held", nz_cnt2, 3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
